obi_to_axil_bridge: RTL and testbench
=====================================

// Module: obi_to_axil_bridge
// PURPOSE
//  Converts one cv32e40p OBI master port (instruction or data) into a single
//  AXI4-Lite master port, which drives one slave port of the AXI-Lite
//  crossbar (INSTR=0, DATA=1). One transaction is outstanding at a time.
//  The OBI response is registered, and the bridge can grant a new request in
//  the same cycle as it returns the previous response.
// PARAMETERS
//  ADDR_WIDTH  32      OBI/AXI address width
//  DATA_WIDTH  32      data width; STRB = DATA_WIDTH/8
//  AXI_PROT    3'b000  constant driven on aw_prot/ar_prot (instr port: 3'b100)
// PORTS
//  clk_i          in   1       clock
//  rst_ni         in   1       asynchronous reset, active-low
//  obi_req_i      in   1       OBI request
//  obi_gnt_o      out  1       OBI grant (request accepted)
//  obi_addr_i     in   AW      byte address
//  obi_we_i       in   1       1 = write
//  obi_be_i       in   STRB    byte enables
//  obi_wdata_i    in   DW      write data
//  obi_rvalid_o   out  1       response valid, 1-cycle pulse
//  obi_rdata_o    out  DW      read data (valid with rvalid, reads only)
//  obi_err_o      out  1       bus error (valid with rvalid)
//  m_aw_addr/prot/valid  out  AW/3/1   AXI-Lite write address
//  m_aw_ready     in   1
//  m_w_data/strb/valid   out  DW/STRB/1  AXI-Lite write data
//  m_w_ready      in   1
//  m_b_resp       in   2       write response
//  m_b_valid      in   1
//  m_b_ready      out  1
//  m_ar_addr/prot/valid  out  AW/3/1   AXI-Lite read address
//  m_ar_ready     in   1
//  m_r_data       in   DW
//  m_r_resp       in   2
//  m_r_valid      in   1
//  m_r_ready      out  1
// BEHAVIOUR
//  States: IDLE, WR (AW/W outstanding), WAIT_B, RD_A (AR outstanding),
//   WAIT_R.
//  Reset: state=IDLE; all valids, b_ready, r_ready, obi_gnt_o, obi_rvalid_o
//   =0; rdata=0; err=0. Reset mid-transaction abandons it, with no response.
//  obi_gnt_o = obi_req_i & (state==IDLE), combinational. On grant, register
//   addr/we/be/wdata; the next state is WR (we=1) or RD_A.
//  Addresses: m_aw_addr = m_ar_addr = {addr[AW-1:2],2'b00}. m_w_strb = be.
//   m_w_data = wdata.
//  WR: aw_valid and w_valid both rise in the cycle after grant. Each drops
//   independently the cycle after its own valid&ready. The state moves to
//   WAIT_B once both handshakes have completed, including when both complete
//   in the same cycle.
//  b_ready = 1 in WR and WAIT_B. A B handshake completes the write (AXI
//   slaves only send B after AW and W have both been accepted).
//  RD_A: ar_valid = 1 until ar_ready, then WAIT_R. r_ready = 1 in WAIT_R.
//  Completion (B or R handshake):
//   - state <= IDLE;
//   - obi_rvalid_o <= 1 in the next cycle, exactly one cycle long;
//   - obi_err_o <= resp[1] (SLVERR/DECERR -> 1; OKAY/EXOKAY -> 0);
//   - obi_rdata_o <= r_data on reads; on writes it holds its old value.
//  Latency, with ready always high: grant at T0, AXI valid at T1, B/R
//   accepted at T2, obi_rvalid_o at T3. rvalid never occurs in the grant
//   cycle.
//  Back-to-back: in the rvalid cycle the state is IDLE, so a new grant can
//   fire in that same cycle.
//  AXI valids never drop before their handshake. Address and data stay
//   stable while their valid is high.
// TESTING
//  1. Write addr 0x1000_0006, be=4'b1100, wdata=0xDEAD_BEEF; AW/W ready=1 and
//     B OKAY -> aw_addr=0x1000_0004, strb=1100, rvalid at T3, err=0.
//  2. Read 0x0000_0010; r_data=0x1234_5678 OKAY after 3 stall cycles ->
//     obi_rdata_o=0x1234_5678, err=0, rvalid once.
//  3. Write with w_ready=1 at T1 and aw_ready delayed to T4 -> w_valid drops
//     at T2, aw_valid holds until T4, and B is accepted only after that.
//  4. Read to an unmapped address; crossbar returns DECERR (2'b11) -> err=1,
//     single rvalid pulse.
//  5. Write followed immediately by a read (req held) -> the read's gnt fires
//     in the write's rvalid cycle, with no idle bubble.
//  6. Assert rst_ni=0 in WAIT_R -> all outputs reset asynchronously, no
//     rvalid; after release, a new read completes normally.

Source files
------------

// File: rtl/obi_to_axil_bridge.sv
// Bridges one OBI master port onto a single AXI4-Lite master port.
// One transaction is in flight at a time, and the OBI response is registered.
module obi_to_axil_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // OBI slave side
  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
  output logic                    obi_rvalid_o,
  output logic [DATA_WIDTH-1:0]   obi_rdata_o,
  output logic                    obi_err_o,
  // AXI4-Lite master side
  output logic [ADDR_WIDTH-1:0]   m_aw_addr,
  output logic [2:0]              m_aw_prot,
  output logic                    m_aw_valid,
  input  logic                    m_aw_ready,
  output logic [DATA_WIDTH-1:0]   m_w_data,
  output logic [DATA_WIDTH/8-1:0] m_w_strb,
  output logic                    m_w_valid,
  input  logic                    m_w_ready,
  input  logic [1:0]              m_b_resp,
  input  logic                    m_b_valid,
  output logic                    m_b_ready,
  output logic [ADDR_WIDTH-1:0]   m_ar_addr,
  output logic [2:0]              m_ar_prot,
  output logic                    m_ar_valid,
  input  logic                    m_ar_ready,
  input  logic [DATA_WIDTH-1:0]   m_r_data,
  input  logic [1:0]              m_r_resp,
  input  logic                    m_r_valid,
  output logic                    m_r_ready,
  // current FSM state, for observation only
  output logic [2:0]              dbg_state
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Handshake rule on every channel: a transfer happens on a rising clk_i edge
  // where valid and ready are both high; valid, once raised, holds (with its
  // payload stable) until that edge, and ready may change freely.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WAIT_B = 3'd2,
    RD_A   = 3'd3,
    WAIT_R = 3'd4
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-3:0] addr_q;
  logic [STRB_WIDTH-1:0] be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  aw_valid_q;
  logic                  w_valid_q;
  logic                  ar_valid_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic grant;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_left, w_left;
  logic unused_inputs;

  assign grant = obi_req_i && (state == IDLE);

  assign aw_hs = aw_valid_q && m_aw_ready;
  assign w_hs  = w_valid_q && m_w_ready;
  assign ar_hs = ar_valid_q && m_ar_ready;
  assign b_hs  = m_b_valid && m_b_ready;
  assign r_hs  = m_r_valid && m_r_ready;

  // A write channel is still open if its valid survives the current edge.
  assign aw_left = aw_valid_q && !m_aw_ready;
  assign w_left  = w_valid_q && !m_w_ready;

  // Only resp[1] distinguishes error from success; the low address bits are
  // replaced by the word alignment.
  assign unused_inputs = ^{m_b_resp[0], m_r_resp[0], obi_addr_i[1:0]};

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant) state_next = obi_we_i ? WR : RD_A;
      end
      WR: begin
        if (b_hs)                     state_next = IDLE;
        else if (!aw_left && !w_left) state_next = WAIT_B;
      end
      WAIT_B: begin
        if (b_hs) state_next = IDLE;
      end
      RD_A: begin
        if (ar_hs) state_next = WAIT_R;
      end
      WAIT_R: begin
        if (r_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request payload is captured only on grant, which keeps it stable while
  // any AXI valid is up.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      addr_q  <= obi_addr_i[ADDR_WIDTH-1:2];
      be_q    <= obi_be_i;
      wdata_q <= obi_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
    end else if (grant) begin
      aw_valid_q <= obi_we_i;
      w_valid_q  <= obi_we_i;
      ar_valid_q <= !obi_we_i;
    end else begin
      if (aw_hs) aw_valid_q <= 1'b0;
      if (w_hs)  w_valid_q  <= 1'b0;
      if (ar_hs) ar_valid_q <= 1'b0;
    end
  end

  // b_ready/r_ready are only high in states owning that response, so either
  // handshake marks completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= b_hs || r_hs;
      if (b_hs) begin
        err_q <= m_b_resp[1];
      end else if (r_hs) begin
        err_q   <= m_r_resp[1];
        rdata_q <= m_r_data;
      end
    end
  end

  assign obi_gnt_o    = grant;
  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;
  assign obi_err_o    = err_q;

  assign m_aw_addr  = {addr_q, 2'b00};
  assign m_aw_prot  = AXI_PROT;
  assign m_aw_valid = aw_valid_q;
  assign m_w_data   = wdata_q;
  assign m_w_strb   = be_q;
  assign m_w_valid  = w_valid_q;
  assign m_b_ready  = (state == WR) || (state == WAIT_B);
  assign m_ar_addr  = {addr_q, 2'b00};
  assign m_ar_prot  = AXI_PROT;
  assign m_ar_valid = ar_valid_q;
  assign m_r_ready  = (state == WAIT_R);

  assign dbg_state = state;

endmodule

// File: tb/tb_obi_to_axil_bridge.sv
// Bench for obi_to_axil_bridge: an AXI-Lite slave with programmable stalls
// plus a transaction-level model of OBI responses and channel activity.
module tb_obi_to_axil_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int EW = DW + 1;
  localparam logic [2:0] PROT = 3'b000;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          obi_req_i = 1'b0;
  logic          obi_gnt_o;
  logic [AW-1:0] obi_addr_i = '0;
  logic          obi_we_i = 1'b0;
  logic [SW-1:0] obi_be_i = '0;
  logic [DW-1:0] obi_wdata_i = '0;
  logic          obi_rvalid_o;
  logic [DW-1:0] obi_rdata_o;
  logic          obi_err_o;
  logic [AW-1:0] m_aw_addr;
  logic [2:0]    m_aw_prot;
  logic          m_aw_valid;
  logic          m_aw_ready = 1'b0;
  logic [DW-1:0] m_w_data;
  logic [SW-1:0] m_w_strb;
  logic          m_w_valid;
  logic          m_w_ready = 1'b0;
  logic [1:0]    m_b_resp = 2'b00;
  logic          m_b_valid = 1'b0;
  logic          m_b_ready;
  logic [AW-1:0] m_ar_addr;
  logic [2:0]    m_ar_prot;
  logic          m_ar_valid;
  logic          m_ar_ready = 1'b0;
  logic [DW-1:0] m_r_data = '0;
  logic [1:0]    m_r_resp = 2'b00;
  logic          m_r_valid = 1'b0;
  logic          m_r_ready;
  logic [2:0]    dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  obi_to_axil_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_PROT(PROT)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
    .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .m_aw_addr(m_aw_addr), .m_aw_prot(m_aw_prot), .m_aw_valid(m_aw_valid),
    .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_ar_addr(m_ar_addr), .m_ar_prot(m_ar_prot), .m_ar_valid(m_ar_valid),
    .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // slave configuration, set by the tests before each request
  int         aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0] b_resp_cfg = 2'b00;
  logic [1:0] r_resp_cfg = 2'b00;
  logic [DW-1:0] r_data_cfg = '0;

  // AXI-Lite slave: drives its inputs 1 ns after each falling edge
  bit aw_acc, w_acc, ar_acc, aw_v_q, w_v_q, ar_v_q, b_r_q, r_r_q;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;

  always begin
    @(negedge clk);
    #1;
    if (!rst_ni) begin
      aw_acc = 0; w_acc = 0; ar_acc = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      m_aw_ready = 0; m_w_ready = 0; m_ar_ready = 0; m_b_valid = 0; m_r_valid = 0;
    end else begin
      if (aw_v_q && m_aw_ready) aw_acc = 1;
      if (w_v_q && m_w_ready)   w_acc = 1;
      if (ar_v_q && m_ar_ready) ar_acc = 1;
      if (m_b_valid && b_r_q) begin
        m_b_valid = 0; aw_acc = 0; w_acc = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      end
      if (m_r_valid && r_r_q) begin
        m_r_valid = 0; ar_acc = 0; ar_wait = 0; r_wait = 0;
      end
      m_aw_ready = 0;
      if (m_aw_valid && !aw_acc) begin m_aw_ready = (aw_wait >= aw_lat); aw_wait++; end
      m_w_ready = 0;
      if (m_w_valid && !w_acc) begin m_w_ready = (w_wait >= w_lat); w_wait++; end
      m_ar_ready = 0;
      if (m_ar_valid && !ar_acc) begin m_ar_ready = (ar_wait >= ar_lat); ar_wait++; end
      if (aw_acc && w_acc && !m_b_valid) begin
        if (b_wait >= b_lat) begin m_b_valid = 1; m_b_resp = b_resp_cfg; end
        else b_wait++;
      end
      if (ar_acc && !m_r_valid) begin
        if (r_wait >= r_lat) begin m_r_valid = 1; m_r_data = r_data_cfg; m_r_resp = r_resp_cfg; end
        else r_wait++;
      end
    end
    aw_v_q = m_aw_valid; w_v_q = m_w_valid; ar_v_q = m_ar_valid;
    b_r_q = m_b_ready; r_r_q = m_r_ready;
  end

  // transaction-level model and per-cycle compare
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  int            cyc = 0, grant_cyc = 0, last_lat = 0, rv_count = 0;
  logic [DW-1:0] last_rdata_seen = '0;
  logic          last_err_seen = 1'b0;
  logic [DW-1:0] model_rdata = '0;
  bit            outstanding, cur_we, aw_done, w_done, ar_done, pa_v, pw_v, par_v, prev_rv;
  logic [AW-1:0] cur_addr;
  logic [SW-1:0] cur_be;
  logic [DW-1:0] cur_wdata;

  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_q.delete();
      outstanding = 0; model_rdata = '0;
      pa_v = 0; pw_v = 0; par_v = 0; prev_rv = 0;
      aw_done = 0; w_done = 0; ar_done = 0;
    end else begin
      cyc++;
      if (pa_v && m_aw_ready) aw_done = 1;
      if (pw_v && m_w_ready)  w_done = 1;
      if (par_v && m_ar_ready) ar_done = 1;
      if (obi_rvalid_o) begin
        if (exp_q.size() == 0) begin
          check("rvalid_unexpected", 1, 0);
        end else begin
          exp_e = exp_q.pop_front();
          check("obi_rdata", obi_rdata_o, exp_e[DW-1:0]);
          check("obi_err", obi_err_o, exp_e[DW]);
        end
        check("rvalid_min_latency", (cyc - grant_cyc) >= 3, 1);
        last_lat = cyc - grant_cyc;
        last_rdata_seen = obi_rdata_o;
        last_err_seen = obi_err_o;
        rv_count++;
        outstanding = 0;
      end
      check("rvalid_single_pulse", obi_rvalid_o && prev_rv, 0);
      check("obi_gnt", obi_gnt_o, obi_req_i && !outstanding);
      check("aw_valid", m_aw_valid, outstanding && cur_we && !aw_done);
      check("w_valid", m_w_valid, outstanding && cur_we && !w_done);
      check("ar_valid", m_ar_valid, outstanding && !cur_we && !ar_done);
      check("b_ready", m_b_ready, outstanding && cur_we);
      check("r_ready", m_r_ready, outstanding && !cur_we && ar_done);
      if (m_aw_valid) begin
        check("aw_addr", m_aw_addr, {cur_addr[AW-1:2], 2'b00});
        check("aw_prot", m_aw_prot, PROT);
      end
      if (m_w_valid) begin
        check("w_data", m_w_data, cur_wdata);
        check("w_strb", m_w_strb, cur_be);
      end
      if (m_ar_valid) begin
        check("ar_addr", m_ar_addr, {cur_addr[AW-1:2], 2'b00});
        check("ar_prot", m_ar_prot, PROT);
      end
      if (obi_req_i && obi_gnt_o) begin
        outstanding = 1; cur_we = obi_we_i; cur_addr = obi_addr_i;
        cur_be = obi_be_i; cur_wdata = obi_wdata_i;
        aw_done = 0; w_done = 0; ar_done = 0; grant_cyc = cyc;
        if (obi_we_i) begin
          exp_q.push_back({b_resp_cfg[1], model_rdata});
        end else begin
          model_rdata = r_data_cfg;
          exp_q.push_back({r_resp_cfg[1], r_data_cfg});
        end
      end
      if (outstanding && (cyc - grant_cyc) > 200) begin
        check("response_timeout", 0, 1);
        outstanding = 0;
        exp_q.delete();
      end
      pa_v = m_aw_valid; pw_v = m_w_valid; par_v = m_ar_valid; prev_rv = obi_rvalid_o;
    end
  end

  // driver tasks
  task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [SW-1:0] be,
                       input logic [DW-1:0] wdata);
    @(posedge clk); #1;
    obi_req_i = 1; obi_we_i = we; obi_addr_i = addr; obi_be_i = be; obi_wdata_i = wdata;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (obi_gnt_o) return;
    end
    check("gnt_timeout", 0, 1);
  endtask

  task automatic end_req();
    @(posedge clk); #1;
    obi_req_i = 0;
  endtask

  task automatic wait_resp(input int start);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #2;
      if (rv_count != start) return;
    end
    check("wait_resp_timeout", 0, 1);
  endtask

  task automatic set_slave(input int awl, input int wl, input int bl, input int arl, input int rl,
                           input logic [1:0] bresp, input logic [1:0] rresp, input logic [DW-1:0] rdata);
    aw_lat = awl; w_lat = wl; b_lat = bl; ar_lat = arl; r_lat = rl;
    b_resp_cfg = bresp; r_resp_cfg = rresp; r_data_cfg = rdata;
  endtask

  task automatic run_txn(input bit we, input logic [AW-1:0] addr, input logic [SW-1:0] be,
                         input logic [DW-1:0] wdata);
    int start;
    start = rv_count;
    issue(we, addr, be, wdata);
    end_req();
    wait_resp(start);
  endtask

  initial begin
    int start;
    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", obi_gnt_o, 0);
    check("rst_rvalid", obi_rvalid_o, 0);
    check("rst_rdata", obi_rdata_o, 0);
    check("rst_err", obi_err_o, 0);
    check("rst_valids", {m_aw_valid, m_w_valid, m_ar_valid}, 3'b000);
    check("rst_readies", {m_b_ready, m_r_ready}, 2'b00);
    #2 rst_ni = 1;

    // 1: aligned write, zero-stall slave
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, '0);
    start = rv_count;
    issue(1, 32'h1000_0006, 4'b1100, 32'hDEAD_BEEF);
    end_req();
    @(negedge clk);
    check("t1_aw_addr", m_aw_addr, 32'h1000_0004);
    check("t1_w_strb", m_w_strb, 4'b1100);
    check("t1_w_data", m_w_data, 32'hDEAD_BEEF);
    check("t1_valids_T1", {m_aw_valid, m_w_valid}, 2'b11);
    wait_resp(start);
    check("t1_latency", last_lat, 3);
    check("t1_err", last_err_seen, 0);

    // 2: read with three R stall cycles
    set_slave(0, 0, 0, 0, 3, 2'b00, 2'b00, 32'h1234_5678);
    run_txn(0, 32'h0000_0010, 4'b1111, '0);
    check("t2_rdata", last_rdata_seen, 32'h1234_5678);
    check("t2_err", last_err_seen, 0);
    check("t2_latency", last_lat, 6);

    // 3: W accepted at T1, AW held until T4; SLVERR response
    set_slave(3, 0, 0, 0, 0, 2'b10, 2'b00, '0);
    start = rv_count;
    issue(1, 32'h2000_0000, 4'b0011, 32'h0102_0304);
    end_req();
    @(negedge clk);
    check("t3_valids_T1", {m_aw_valid, m_w_valid}, 2'b11);
    @(negedge clk);
    check("t3_valids_T2", {m_aw_valid, m_w_valid}, 2'b10);
    repeat (2) @(negedge clk);
    check("t3_aw_valid_T4", m_aw_valid, 1);
    @(negedge clk);
    check("t3_aw_valid_T5", m_aw_valid, 0);
    wait_resp(start);
    check("t3_latency", last_lat, 6);
    check("t3_err", last_err_seen, 1);
    check("t3_rdata_held", last_rdata_seen, 32'h1234_5678);

    // 4: DECERR read
    set_slave(0, 0, 0, 1, 0, 2'b00, 2'b11, 32'hBAD0_BAD0);
    start = rv_count;
    run_txn(0, 32'hF000_0000, 4'b1111, '0);
    check("t4_err", last_err_seen, 1);
    repeat (4) @(negedge clk);
    check("t4_single_rvalid", rv_count, start + 1);

    // 5: write then read back-to-back, request never dropped
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hCAFE_F00D);
    start = rv_count;
    issue(1, 32'h0000_0020, 4'b1111, 32'h5A5A_A5A5);
    issue(0, 32'h0000_0024, 4'b1111, '0);
    check("t5_gnt_in_rvalid_cycle", obi_rvalid_o, 1);
    end_req();
    wait_resp(start + 1);
    check("t5_rdata", last_rdata_seen, 32'hCAFE_F00D);
    check("t5_read_latency", last_lat, 3);

    // mixed stalls and response codes
    set_slave(1, 2, 1, 0, 0, 2'b01, 2'b00, '0);
    run_txn(1, 32'h3000_0001, 4'b0001, 32'h0000_00AA);
    set_slave(0, 0, 0, 2, 0, 2'b00, 2'b01, 32'h5555_AAAA);
    run_txn(0, 32'h3000_0002, 4'b1111, '0);
    set_slave(0, 3, 2, 0, 0, 2'b11, 2'b00, '0);
    run_txn(1, 32'h3000_000B, 4'b1111, 32'h8765_4321);
    set_slave(0, 0, 0, 0, 1, 2'b00, 2'b10, 32'h0F0F_0F0F);
    run_txn(0, 32'h3000_000F, 4'b1111, '0);
    set_slave(2, 2, 0, 0, 0, 2'b00, 2'b00, '0);
    run_txn(1, 32'h3000_0010, 4'b1010, 32'hFFFF_0000);
    check("mix_rdata_held", last_rdata_seen, 32'h0F0F_0F0F);

    // 6: reset while waiting for R
    set_slave(0, 0, 0, 0, 20, 2'b00, 2'b00, 32'h7777_7777);
    start = rv_count;
    issue(0, 32'h0000_0040, 4'b1111, '0);
    end_req();
    for (int i = 0; i < 50 && !m_r_ready; i++) @(negedge clk);
    check("t6_reached_wait_r", m_r_ready, 1);
    #3 rst_ni = 0;
    #1;
    check("t6_rst_rvalid", obi_rvalid_o, 0);
    check("t6_rst_rdata", obi_rdata_o, 0);
    check("t6_rst_err", obi_err_o, 0);
    check("t6_rst_valids", {m_aw_valid, m_w_valid, m_ar_valid}, 3'b000);
    check("t6_rst_readies", {m_b_ready, m_r_ready}, 2'b00);
    repeat (3) @(negedge clk);
    #3 rst_ni = 1;
    repeat (5) @(negedge clk);
    #2;
    check("t6_no_rvalid_after_reset", rv_count, start);
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h600D_600D);
    run_txn(0, 32'h0000_0044, 4'b1111, '0);
    check("t6_rdata_after_reset", last_rdata_seen, 32'h600D_600D);
    check("t6_latency_after_reset", last_lat, 3);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
